normalizer: RTL and testbench

//  Iterative left-normalizer for the 16-bit datapath; the inverse of the barrel-shift SLL path.

---
 rtl/normalizer.sv | 127 ++++++++++++
 tb/tb_normalizer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/normalizer.sv
// normalizer: iterative left-normalizer for the 16-bit datapath.
// Shifts the latched operand left one bit per cycle until it reaches
// normalized form, then reports the normalized value, the number of
// shifts applied and a {S,Z,C,V} condition code. The handshake is
// start/busy/done. Results hold until the next completion or reset.
module normalizer #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] x,
   output logic [CNT_W-1:0]  count,
   output logic [3:0]        code
);

   // The shift bounds and the condition-code layout assume a 16-bit word
   // with a 4-bit count. Stop elaboration on any other configuration.
   if (DATA_W != 16 || CNT_W != 4) begin : g_bad_param
      $error("normalizer: DATA_W must be 16 and CNT_W must be 4");
   end

   // Unsigned mode can take up to DATA_W-1 shifts. Signed mode keeps one
   // sign bit, so it can take at most DATA_W-2 shifts.
   localparam logic [CNT_W-1:0] MAX_U = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] MAX_S = CNT_W'(DATA_W - 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_work;   // operand being shifted
   logic              r_md;     // latched mode: 1 = signed
   logic [CNT_W-1:0]  r_cnt;    // shifts applied so far
   logic              r_busy;
   logic              r_done;
   logic [DATA_W-1:0] r_x;
   logic [CNT_W-1:0]  r_count;
   logic [3:0]        r_code;

   logic              w_zero;
   logic              w_ones;
   logic              w_norm;
   logic              w_unnorm;
   logic              w_at_max;
   logic              w_term;

   // Termination test on the current working value
   assign w_zero   = (r_work == {DATA_W{1'b0}});
   assign w_ones   = (r_work == {DATA_W{1'b1}});
   assign w_norm   = r_md ? (r_work[DATA_W-1] ^ r_work[DATA_W-2])
                          :  r_work[DATA_W-1];
   // All-zero (or all-ones when signed) operands can never be normalized.
   // They are detected on the first SHIFT cycle, so they finish with count 0.
   assign w_unnorm = r_md ? (w_zero | w_ones) : w_zero;
   // The signed bound is never reached in practice. It is kept only as a
   // backstop against a runaway shift.
   assign w_at_max = (r_cnt == (r_md ? MAX_S : MAX_U));
   assign w_term   = w_norm | w_unnorm | w_at_max;

   // Control FSM: accept, shift until done, pulse done, return to idle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_work  <= '0;
         r_md    <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_x     <= '0;
         r_count <= '0;
         r_code  <= 4'b0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  // Results stay visible; only the working copy is reloaded
                  r_work  <= b;
                  r_md    <= mode;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_term) begin
                  r_x     <= r_work;
                  r_count <= r_cnt;
                  r_code  <= {r_work[DATA_W-1], w_zero, w_unnorm, 1'b0};
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_work  <= {r_work[DATA_W-2:0], 1'b0};
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               // start is not looked at here. The earliest restart is in IDLE.
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign x     = r_x;
   assign count = r_count;
   assign code  = r_code;

endmodule

// File: tb/tb_normalizer.sv
// tb_normalizer: scenario tests for the iterative normalizer. Expected
// results are queued when an operation is accepted. A monitor pops and
// compares each queued result when done pulses.
module tb_normalizer;

   typedef struct packed {
      logic [15:0] x;
      logic [3:0]  count;
      logic [3:0]  code;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] x;
   logic [3:0]  count;
   logic [3:0]  code;

   exp_t sb[$];
   exp_t mon_exp;
   int   n_pass  = 0;
   int   n_total = 0;
   int   n_txn   = 0;

   normalizer #(.DATA_W(16), .CNT_W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mode  (mode),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .x     (x),
      .count (count),
      .code  (code)
   );

   always #5 clk = ~clk;

   // Hard stop in case something hangs despite the bounded waits
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [15:0] ex, input logic [3:0] ec, input logic [3:0] ecode);
      exp_t e;
      e.x = ex; e.count = ec; e.code = ecode;
      return e;
   endfunction

   // Reference: count leading zeros (unsigned) or redundant sign bits (signed)
   function automatic exp_t model(input logic m, input logic [15:0] v);
      exp_t e;
      int   n;
      logic c;
      n = 0;
      c = 1'b0;
      if (!m) begin
         if (v == 16'h0000) c = 1'b1;
         else while (v[15-n] == 1'b0) n++;
      end else begin
         if (v == 16'h0000 || v == 16'hFFFF) c = 1'b1;
         else while (v[14-n] == v[15]) n++;
      end
      e.x     = v << n;
      e.count = n[3:0];
      e.code  = {e.x[15], (e.x == 16'h0000), c, 1'b0};
      return e;
   endfunction

   // Scoreboard monitor: every done pulse consumes one queued expectation
   always @(posedge clk) begin
      #1;
      if (done === 1'b1) begin
         n_total++;
         n_txn++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_done: got x=%h count=%0d code=%b, required no done", x, count, code);
         end else begin
            mon_exp = sb.pop_front();
            $display("txn %0d: x=%h count=%0d code=%b (expected x=%h count=%0d code=%b)",
                     n_txn, x, count, code, mon_exp.x, mon_exp.count, mon_exp.code);
            if ({x, count, code} !== mon_exp) begin
               $display("FAIL result: got x=%h count=%0d code=%b, required x=%h count=%0d code=%b",
                        x, count, code, mon_exp.x, mon_exp.count, mon_exp.code);
            end else begin
               n_pass++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one accepted request (caller guarantees IDLE) and queue its result
   task automatic launch(input logic m, input logic [15:0] v, input exp_t e);
      start = 1'b1;
      mode  = m;
      b     = v;
      sb.push_back(e);
      step();
      start = 1'b0;
      b     = 16'($urandom);
      mode  = 1'($urandom);
   endtask

   // Wait for done with a cycle budget; returns edges since acceptance
   task automatic wait_done(output int lat, output bit busy_ok, output bit timed_out);
      lat       = 0;
      busy_ok   = 1'b1;
      timed_out = 1'b0;
      while (done !== 1'b1 && !timed_out) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         step();
         lat++;
         if (lat > 40) timed_out = 1'b1;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mode = 1'b0; b = 16'h0000;
      step();
      step();
      rst = 1'b0;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy);
      else n_pass++;
      n_total++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b, required 0", done);
      else n_pass++;
      n_total++;
      if ({x, count, code} !== 24'h0) $display("FAIL reset_outputs: got x=%h count=%0d code=%b, required all 0", x, count, code);
      else n_pass++;
   endtask

   task automatic test_unsigned_max();
      int lat; bit bok; bit tmo;
      launch(1'b0, 16'h0001, mk(16'h8000, 4'd15, 4'b1000));
      wait_done(lat, bok, tmo);
      n_total++;
      if (lat !== 16 || tmo) $display("FAIL u0001_latency: got %0d edges (timeout=%0d), required 16", lat, tmo);
      else n_pass++;
      n_total++;
      if (bok !== 1'b1) $display("FAIL u0001_busy: got busy low during run, required high throughout");
      else n_pass++;
      step();
      n_total++;
      if ({done, busy} !== 2'b00) $display("FAIL u0001_after_done: got done=%b busy=%b, required 0 0", done, busy);
      else n_pass++;
   endtask

   task automatic test_already_normalized();
      int lat; bit bok; bit tmo;
      launch(1'b0, 16'h8000, mk(16'h8000, 4'd0, 4'b1000));
      wait_done(lat, bok, tmo);
      n_total++;
      if (lat !== 1 || tmo) $display("FAIL u8000_latency: got %0d, required 1", lat);
      else n_pass++;
      step();
      launch(1'b0, 16'h0000, mk(16'h0000, 4'd0, 4'b0110));
      wait_done(lat, bok, tmo);
      n_total++;
      if (lat !== 1 || tmo) $display("FAIL u0000_latency: got %0d, required 1", lat);
      else n_pass++;
      step();
   endtask

   task automatic test_signed();
      int lat; bit bok; bit tmo;
      launch(1'b1, 16'h0003, mk(16'h6000, 4'd13, 4'b0000));
      wait_done(lat, bok, tmo);
      n_total++;
      if (lat !== 14 || tmo) $display("FAIL s0003_latency: got %0d, required 14", lat);
      else n_pass++;
      step();
      launch(1'b1, 16'hFFF0, mk(16'h8000, 4'd11, 4'b1000));
      wait_done(lat, bok, tmo);
      n_total++;
      if (lat !== 12 || tmo) $display("FAIL sFFF0_latency: got %0d, required 12", lat);
      else n_pass++;
      step();
      launch(1'b1, 16'hFFFF, mk(16'hFFFF, 4'd0, 4'b1010));
      wait_done(lat, bok, tmo);
      n_total++;
      if (lat !== 1 || tmo) $display("FAIL sFFFF_latency: got %0d, required 1", lat);
      else n_pass++;
      step();
   endtask

   task automatic test_busy_ignore();
      int lat; int dones; bit bok; bit tmo;
      launch(1'b0, 16'h0001, mk(16'h8000, 4'd15, 4'b1000));
      lat = 0;
      dones = 0;
      while (lat < 40 && dones == 0) begin
         start = (lat == 2 || lat == 9);
         b     = 16'h8000;
         mode  = 1'b0;
         step();
         lat++;
         if (done === 1'b1) dones++;
      end
      n_total++;
      if (dones !== 1 || lat !== 16) $display("FAIL ignore_latency: got %0d edges (dones=%0d), required 16 (1)", lat, dones);
      else n_pass++;
      // Hold start through the done cycle; it must be taken only once back in IDLE
      start = 1'b1; b = 16'h8000; mode = 1'b0;
      step();
      n_total++;
      if ({done, busy} !== 2'b00) $display("FAIL done_cycle_start: got done=%b busy=%b, required 0 0", done, busy);
      else n_pass++;
      sb.push_back(mk(16'h8000, 4'd0, 4'b1000));
      step();
      start = 1'b0;
      n_total++;
      if (busy !== 1'b1) $display("FAIL restart_accept: got busy=%b, required 1", busy);
      else n_pass++;
      n_total++;
      if (count !== 4'd15) $display("FAIL hold_count: got %0d, required 15", count);
      else n_pass++;
      wait_done(lat, bok, tmo);
      n_total++;
      if (lat !== 1 || tmo) $display("FAIL restart_latency: got %0d, required 1", lat);
      else n_pass++;
      step();
   endtask

   task automatic test_reset_mid();
      int lat; bit bok; bit tmo;
      launch(1'b0, 16'h0001, mk(16'h8000, 4'd15, 4'b1000));
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      n_total++;
      if ({busy, done} !== 2'b00) $display("FAIL midreset_ctrl: got busy=%b done=%b, required 0 0", busy, done);
      else n_pass++;
      n_total++;
      if ({x, count, code} !== 24'h0) $display("FAIL midreset_outputs: got x=%h count=%0d code=%b, required all 0", x, count, code);
      else n_pass++;
      launch(1'b0, 16'h0100, mk(16'h8000, 4'd7, 4'b1000));
      wait_done(lat, bok, tmo);
      n_total++;
      if (lat !== 8 || tmo) $display("FAIL postreset_latency: got %0d, required 8", lat);
      else n_pass++;
      step();
   endtask

   task automatic test_back_to_back_random();
      int lat; bit bok; bit tmo;
      logic m; logic [15:0] v; exp_t e;
      for (int i = 0; i < 24; i++) begin
         m = 1'($urandom_range(0, 1));
         v = 16'($urandom) >> $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) v = ~v;
         e = model(m, v);
         launch(m, v, e);
         wait_done(lat, bok, tmo);
         n_total++;
         if (lat !== int'(e.count) + 1 || tmo || !bok)
            $display("FAIL rand_latency: op %0d m=%0d b=%h got %0d edges busy_ok=%0d, required %0d", i, m, v, lat, bok, int'(e.count) + 1);
         else n_pass++;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_max();
      test_already_normalized();
      test_signed();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back_random();
      repeat (3) step();
      n_total++;
      if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
